// File: rtl/dm_resp.sv
// dm_resp: word-addressed data memory responder with programmable wait states and error checking
module dm_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic c_wr, t_wr, t_bad, c_bad, go;
  logic [31:0] c_addr, c_wdata, t_addr, t_wdata;
  logic [3:0] c_be, t_be;
  logic [DEPTH_LOG2-1:0] t_idx;
  logic [31:0] mem [2**DEPTH_LOG2];
  // Next state, and the transaction view: live inputs when RESP is entered straight from IDLE, captured copy otherwise
  always_comb begin
    go = (state == IDLE && req && WAIT_CYCLES == 0) || (state == WAIT && cnt == 3'd1);
    state_nx = state == IDLE ? (req ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
               state == WAIT ? (cnt == 3'd1 ? RESP : WAIT) : IDLE;
    cnt_nx = state == IDLE ? (req ? 3'(WAIT_CYCLES) : 3'd0) : state == WAIT ? cnt - 3'd1 : 3'd0;
    t_wr = state == IDLE ? wr : c_wr;
    t_addr = state == IDLE ? addr : c_addr;
    t_wdata = state == IDLE ? wdata : c_wdata;
    t_be = state == IDLE ? be : c_be;
    t_bad = (|t_addr[1:0]) || (|t_addr[31:DEPTH_LOG2+2]);
    c_bad = (|c_addr[1:0]) || (|c_addr[31:DEPTH_LOG2+2]);
    t_idx = t_addr[DEPTH_LOG2+1:2];
    ack = state == RESP;
    err = state == RESP && c_bad;
    busy = state != IDLE;
  end
  // Control state, wait counter and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      rdata <= 32'h0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (go && !t_wr) rdata <= t_bad ? 32'h0 : mem[t_idx];
    end
  end
  // Request capture; later input changes cannot disturb the in-flight transaction
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      c_wr <= wr;
      c_addr <= addr;
      c_wdata <= wdata;
      c_be <= be;
    end
  end
  // Byte-masked write commit on the edge entering RESP; storage survives reset
  always_ff @(posedge clk) begin
    if (!rst && go && t_wr && !t_bad)
      for (int i = 0; i < 4; i++)
        if (t_be[i]) mem[t_idx][8*i +: 8] <= t_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dm_resp.sv
// tb_dm_resp: directed self-checking bench over four wait-state configurations
module tb_dm_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_v = 4'b0;
  logic wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0] be = 4'h0;
  logic [31:0] rdata_v [4];
  logic [3:0] ack_v, err_v, busy_v;
  int n_chk = 0;
  int n_fail = 0;
  int wcs [4] = '{1, 0, 7, 3};
  logic [31:0] rd;
  logic e;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dm_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 7 : 3)) u (
      .clk(clk), .rst(rst), .req(req_v[g]), .wr(wr), .addr(addr), .wdata(wdata), .be(be),
      .rdata(rdata_v[g]), .ack(ack_v[g]), .err(err_v[g]), .busy(busy_v[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input int k, input logic wr_i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] r, output logic er);
    int lat;
    req_v[k] = 1'b1;
    wr = wr_i;
    addr = a;
    wdata = d;
    be = b;
    @(posedge clk); #1;
    wr = ~wr_i;
    addr = 32'hFFFF_FFFF;
    wdata = 32'h0BAD_0BAD;
    be = 4'hF;
    lat = 1;
    while (!ack_v[k] && lat < 20) begin
      chk("busy_wait", 32'(busy_v[k]), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk("ack_seen", 32'(ack_v[k]), 32'd1);
    chk("latency", lat, wcs[k] + 1);
    chk("busy_resp", 32'(busy_v[k]), 32'd1);
    r = rdata_v[k];
    er = err_v[k];
    @(posedge clk); #1;
    req_v[k] = 1'b0;
    chk("no_recapture_busy", 32'(busy_v[k]), 32'd0);
    chk("ack_single", 32'(ack_v[k]), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack_v), 32'h0);
    chk("rst_err", 32'(err_v), 32'h0);
    chk("rst_busy", 32'(busy_v), 32'h0);
    for (int k = 0; k < 4; k++) chk("rst_rdata", rdata_v[k], 32'h0);
    rst = 1'b0;
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e);
    chk("wr10_err", 32'(e), 32'h0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_err", 32'(e), 32'h0);
    xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, e);
    chk("wr20_rdata_hold", rd, 32'hDEADBEEF);
    xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, e);
    chk("lane_data", rd, 32'h11BB33DD);
    xact(0, 1'b1, 32'h20, 32'h0, 4'h0, rd, e);
    chk("be0_err", 32'(e), 32'h0);
    chk("be0_rdata_hold", rd, 32'h11BB33DD);
    xact(0, 1'b0, 32'h22, 32'h0, 4'hF, rd, e);
    chk("mis_err", 32'(e), 32'h1);
    chk("mis_rdata", rd, 32'h0);
    xact(0, 1'b1, 32'h20, 32'h1, 4'h0, rd, e);
    xact(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, rd, e);
    chk("oor_err", 32'(e), 32'h1);
    chk("oor_rdata", rd, 32'h0);
    xact(0, 1'b1, 32'h21, 32'h0, 4'hF, rd, e);
    chk("wr_mis_err", 32'(e), 32'h1);
    xact(0, 1'b1, 32'h0000_1020, 32'h0, 4'hF, rd, e);
    chk("wr_oor_err", 32'(e), 32'h1);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, e);
    chk("word20_kept", rd, 32'h11BB33DD);
    chk("word20_err", 32'(e), 32'h0);
    xact(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, e);
    xact(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, e);
    chk("w0_raw", rd, 32'hCAFEF00D);
    xact(2, 1'b1, 32'h8, 32'h0102_0304, 4'hF, rd, e);
    xact(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, e);
    chk("w7_data", rd, 32'h0102_0304);
    xact(3, 1'b1, 32'h30, 32'h1234_5678, 4'hF, rd, e);
    req_v[3] = 1'b1;
    wr = 1'b1;
    addr = 32'h30;
    wdata = 32'h5555_5555;
    be = 4'hF;
    @(posedge clk); #1;
    req_v[3] = 1'b0;
    chk("abort_busy_w1", 32'(busy_v[3]), 32'd1);
    @(posedge clk); #1;
    chk("abort_busy_w2", 32'(busy_v[3]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy_v[3]), 32'd0);
    chk("abort_ack", 32'(ack_v[3]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", 32'(ack_v[3]), 32'd0);
    end
    xact(3, 1'b0, 32'h30, 32'h0, 4'h0, rd, e);
    chk("abort_prior", rd, 32'h1234_5678);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 Parameter: DEPTH_LOG2, 10, word-address width of the backing store (2^DEPTH_LOG2 32-bit words).
REQ-002 Parameter: WAIT_CYCLES, 1, wait states inserted between request capture and response (legal 0..7).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  1  request valid from the CPU data port; held high until ack.
REQ-006 wr  input  1  1 = write, 0 = read; qualified by req.
REQ-007 addr  input  32  byte address; word index = addr[DEPTH_LOG2+1:2].
REQ-008 wdata  input  32  write data.
REQ-009 be  input  4  byte enables for writes; be[i] enables wdata[8i+7:8i].
REQ-010 rdata  output  32  read data; registered; valid when ack=1 and wr was 0.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 err  output  1  error flag; valid only while ack=1.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 IDLE: on a posedge with req=1, capture wr/addr/wdata/be into internal registers; next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 WAIT: load a 3-bit counter with WAIT_CYCLES on entry, decrement each cycle, and transition to RESP on the edge where the counter equals 1.
REQ-017 RESP: ack=1 for exactly one cycle; next state is IDLE unconditionally.
REQ-018 Latency: ack is high in cycle N+WAIT_CYCLES+1, where N is the cycle in which req is sampled in IDLE.
REQ-019 A req that is high in the RESP cycle is not captured; capture resumes in IDLE, so the minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-020 Error condition, evaluated on the captured values: addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0.
REQ-021 Error response: err=1 with ack; no memory write; rdata=32'h0000_0000 for an errored read.
REQ-022 Write commit: on the edge entering RESP, only the enabled bytes of the addressed word are updated; be=4'b0000 is a no-op that is still acked with err=0.
REQ-023 Read: on the edge entering RESP, rdata loads the full addressed word regardless of be.
REQ-024 rdata holds its value until the next read completes; writes do not alter rdata.
REQ-025 A read from the word written by the immediately preceding transaction returns the newly written data.
REQ-026 Inputs that change after capture (including req dropping early) do not affect the in-flight transaction, which runs to completion.
REQ-027 Storage is a 2^DEPTH_LOG2 x 32 register array; the array is not cleared by reset.

Reset
REQ-028 While rst=1 at a posedge: state becomes IDLE, the wait counter becomes 0, ack=0, err=0, busy=0, rdata=0.
REQ-029 Reset asserted mid-transaction aborts it: no ack is produced, and a write that has not yet entered RESP is not committed.
REQ-030 The first request can be captured on the first posedge after rst deasserts.

Verification
REQ-031 WAIT_CYCLES=1: write addr=0x10, wdata=0xDEADBEEF, be=4'hF, then read addr=0x10 -> each ack arrives 2 cycles after capture; read returns rdata=0xDEADBEEF with err=0.
REQ-032 Byte-lane test: write 0x11223344 to addr 0x20 with be=F, then write 0xAABBCCDD with be=4'b0101, then read -> rdata=0x11BB33DD.
REQ-033 Error test: read addr=0x22 (misaligned) and addr=0x0000_1000 (out of range with DEPTH_LOG2=10) -> ack=1, err=1, rdata=0; the existing word at 0x20 is unchanged.
REQ-034 Latency sweep: WAIT_CYCLES=0 gives ack in cycle N+1; WAIT_CYCLES=7 gives ack in cycle N+8 with busy=1 throughout; req held continuously across ack gives no double capture.
REQ-035 Reset abort: start a write of 0x55555555 to addr 0x30 with WAIT_CYCLES=3 and assert rst in the second WAIT cycle -> no ack, busy=0 the next cycle, and a subsequent read of 0x30 returns the prior value.
